// File: rtl/mac8_acc_commit_if.sv
// Handshake bundle between the MAC unit / commit stage and the speculation buffer.
// The block itself connects through the slave modport.
interface mac8_acc_commit_if #(
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                     flush_i;
    logic                     valid_i;
    logic [31:0]              result_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     ready_o;
    logic                     commit_i;
    logic [TRANS_ID_BITS-1:0] commit_trans_id_i;
    logic [31:0]              spec_acc_o;
    logic [31:0]              arch_acc_o;
    logic                     empty_o;
    logic                     full_o;
    logic                     commit_err_o;

    modport master (
        output flush_i, valid_i, result_i, trans_id_i, commit_i, commit_trans_id_i,
        input  ready_o, spec_acc_o, arch_acc_o, empty_o, full_o, commit_err_o
    );

    modport slave (
        input  flush_i, valid_i, result_i, trans_id_i, commit_i, commit_trans_id_i,
        output ready_o, spec_acc_o, arch_acc_o, empty_o, full_o, commit_err_o
    );
endinterface

// File: rtl/mac8_acc_commit.sv
// Speculation buffer plus architectural accumulator for the 8-bit SIMD MAC unit:
// in-order FIFO of speculative results, retired on commit, discarded on flush.
package config_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [7:0] reserved;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module mac8_acc_commit #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    mac8_acc_commit_if.slave bus
);
    localparam int unsigned TRANS_ID_BITS = config_pkg::TRANS_ID_BITS;
    localparam int unsigned PTR_W         = $clog2(DEPTH);
    localparam int unsigned CNT_W         = PTR_W + 1;

    // The core configuration is carried only for integration uniformity.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(CVA6Cfg) == 0) begin : g_param_check
        $error("mac8_acc_commit: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [31:0]              result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        arch_q;
    logic               err_q;

    logic               full;
    logic               empty;
    logic               push;
    logic               commit_ok;
    logic [PTR_W-1:0]   rptr_next;
    logic [PTR_W-1:0]   newest;
    entry_t             head;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        head      = mem_q[rptr_q];
        push      = bus.valid_i && !full && !bus.flush_i;
        commit_ok = bus.commit_i && !empty && (head.trans_id == bus.commit_trans_id_i);
        rptr_next = rptr_q + PTR_W'(commit_ok);
        newest    = wptr_q - PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            arch_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= bus.commit_i && !commit_ok;
            rptr_q <= rptr_next;
            if (commit_ok) begin
                arch_q <= head.result;
            end
            // Flush resolves after the commit: the buffer restarts at the post-commit head.
            if (bus.flush_i) begin
                count_q <= '0;
                wptr_q  <= rptr_next;
            end else begin
                wptr_q  <= wptr_q + PTR_W'(push);
                count_q <= count_q + CNT_W'(push) - CNT_W'(commit_ok);
            end
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= '{result: bus.result_i, trans_id: bus.trans_id_i};
        end
    end

    assign bus.ready_o      = !full;
    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.arch_acc_o   = arch_q;
    assign bus.commit_err_o = err_q;
    assign bus.spec_acc_o   = empty ? arch_q : mem_q[newest].result;
endmodule

// File: tb/tb_mac8_acc_commit.sv
// Directed self-checking bench for mac8_acc_commit with DEPTH = 4.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_mac8_acc_commit;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   drops = 0;

    mac8_acc_commit_if #(.TRANS_ID_BITS(config_pkg::TRANS_ID_BITS)) bus ();

    mac8_acc_commit #(.DEPTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Protocol monitor: issuing while not ready is a producer violation.
    always @(posedge clk_i) begin
        if (rst_ni && bus.valid_i && !bus.ready_o) drops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] res, input logic [2:0] id,
                        input logic c, input logic [2:0] cid, input logic f);
        bus.valid_i           = v;
        bus.result_i          = res;
        bus.trans_id_i        = id;
        bus.commit_i          = c;
        bus.commit_trans_id_i = cid;
        bus.flush_i           = f;
        @(posedge clk_i);
        #1;
        bus.valid_i  = 1'b0;
        bus.commit_i = 1'b0;
        bus.flush_i  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spec"},  bus.spec_acc_o, 32'h0);
        check({tag, "_arch"},  bus.arch_acc_o, 32'h0);
        check({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
        check({tag, "_full"},  32'(bus.full_o), 32'd0);
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        check({tag, "_err"},   32'(bus.commit_err_o), 32'd0);
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.result_i = '0; bus.trans_id_i = '0;
        bus.commit_i = 1'b0; bus.commit_trans_id_i = '0; bus.flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // First push, then retire it.
        step(1, 32'h10, 3'd3, 0, 3'd0, 0);
        check("push1_spec", bus.spec_acc_o, 32'h10);
        check("push1_empty", 32'(bus.empty_o), 32'd0);
        check("push1_arch", bus.arch_acc_o, 32'h0);
        step(0, 32'h0, 3'd0, 1, 3'd3, 0);
        check("c1_arch", bus.arch_acc_o, 32'h10);
        check("c1_empty", 32'(bus.empty_o), 32'd1);
        check("c1_spec", bus.spec_acc_o, 32'h10);

        // Fill to full, drop the fifth, then drain.
        for (int i = 0; i < 4; i++) step(1, 32'(i + 1), 3'(i), 0, 3'd0, 0);
        check("fill_full", 32'(bus.full_o), 32'd1);
        check("fill_ready", 32'(bus.ready_o), 32'd0);
        check("fill_spec", bus.spec_acc_o, 32'd4);
        step(1, 32'h99, 3'd4, 0, 3'd0, 0);
        check("drop_spec", bus.spec_acc_o, 32'd4);
        check("drop_full", 32'(bus.full_o), 32'd1);
        step(0, 32'h0, 3'd0, 1, 3'd0, 0);
        check("drain0_arch", bus.arch_acc_o, 32'd1);
        check("drain0_full", 32'(bus.full_o), 32'd0);
        for (int i = 1; i < 4; i++) step(0, 32'h0, 3'd0, 1, 3'(i), 0);
        check("drain_arch", bus.arch_acc_o, 32'd4);
        check("drain_empty", 32'(bus.empty_o), 32'd1);
        check("drain_err", 32'(bus.commit_err_o), 32'd0);

        // Simultaneous push and commit keeps the count.
        step(1, 32'h50, 3'd5, 0, 3'd0, 0);
        step(1, 32'h60, 3'd6, 0, 3'd0, 0);
        step(1, 32'hFFFF_FFF0, 3'd7, 1, 3'd5, 0);
        check("pc_arch", bus.arch_acc_o, 32'h50);
        check("pc_spec", bus.spec_acc_o, 32'hFFFF_FFF0);
        check("pc_full", 32'(bus.full_o), 32'd0);
        step(0, 32'h0, 3'd0, 1, 3'd6, 0);
        check("pc_c6_arch", bus.arch_acc_o, 32'h60);
        check("pc_c6_empty", 32'(bus.empty_o), 32'd0);
        step(0, 32'h0, 3'd0, 1, 3'd7, 0);
        check("pc_c7_arch", bus.arch_acc_o, 32'hFFFF_FFF0);
        check("pc_c7_empty", 32'(bus.empty_o), 32'd1);

        // Twelve back-to-back push+commit cycles wrap both pointers three times.
        for (int i = 0; i < 12; i++) begin
            step(1, 32'h100 + 32'(i), 3'(i), i > 0, 3'(i - 1), 0);
            check("wrap_spec", bus.spec_acc_o, 32'h100 + 32'(i));
            if (i > 0) check("wrap_arch", bus.arch_acc_o, 32'h100 + 32'(i - 1));
        end
        step(0, 32'h0, 3'd0, 1, 3'd3, 0);
        check("wrap_last_arch", bus.arch_acc_o, 32'h10B);
        check("wrap_last_empty", 32'(bus.empty_o), 32'd1);

        // Flush with a legal commit and a push in the same cycle.
        step(1, 32'd10, 3'd1, 0, 3'd0, 0);
        step(1, 32'd20, 3'd2, 0, 3'd0, 0);
        step(1, 32'd30, 3'd3, 0, 3'd0, 0);
        step(1, 32'd40, 3'd4, 1, 3'd1, 1);
        check("fl_arch", bus.arch_acc_o, 32'd10);
        check("fl_empty", 32'(bus.empty_o), 32'd1);
        check("fl_spec", bus.spec_acc_o, 32'd10);
        step(1, 32'd50, 3'd5, 0, 3'd0, 0);
        check("fl_push_spec", bus.spec_acc_o, 32'd50);
        step(0, 32'h0, 3'd0, 1, 3'd5, 0);
        check("fl_commit_arch", bus.arch_acc_o, 32'd50);
        check("fl_commit_err", 32'(bus.commit_err_o), 32'd0);
        check("fl_commit_empty", 32'(bus.empty_o), 32'd1);

        // Illegal commits: empty buffer, then wrong ID against head ID 2.
        step(0, 32'h0, 3'd0, 1, 3'd0, 0);
        check("ill_empty_err", 32'(bus.commit_err_o), 32'd1);
        check("ill_empty_arch", bus.arch_acc_o, 32'd50);
        check("ill_empty_empty", 32'(bus.empty_o), 32'd1);
        step(1, 32'h22, 3'd2, 0, 3'd0, 0);
        check("ill_err_drop", 32'(bus.commit_err_o), 32'd0);
        step(0, 32'h0, 3'd0, 1, 3'd3, 0);
        check("ill_id_err", 32'(bus.commit_err_o), 32'd1);
        check("ill_id_arch", bus.arch_acc_o, 32'd50);
        check("ill_id_spec", bus.spec_acc_o, 32'h22);
        check("ill_id_empty", 32'(bus.empty_o), 32'd0);
        step(0, 32'h0, 3'd0, 1, 3'd2, 0);
        check("ill_ok_err", 32'(bus.commit_err_o), 32'd0);
        check("ill_ok_arch", bus.arch_acc_o, 32'h22);
        check("ill_ok_empty", 32'(bus.empty_o), 32'd1);

        // Reset mid-operation with three entries and arch = 0x55.
        step(1, 32'h55, 3'd0, 0, 3'd0, 0);
        step(0, 32'h0, 3'd0, 1, 3'd0, 0);
        for (int i = 1; i < 4; i++) step(1, 32'(i), 3'(i), 0, 3'd0, 0);
        check("mid_arch", bus.arch_acc_o, 32'h55);
        check("mid_spec", bus.spec_acc_o, 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_empty", 32'(bus.empty_o), 32'd1);

        check("protocol_drops", 32'(drops), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
